// File: rtl/rr_arb_pkg.sv
// Shared types, constants and helpers for the round-robin arbitrated multiplexer.
package rr_arb_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // Index width for n channels; a single channel still needs a 1-bit index.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DEF_N_CH = 4;
  localparam int unsigned DEF_SELW = clog2_min1(DEF_N_CH);

  typedef logic [DEF_SELW-1:0] ch_idx_t;

endpackage

// File: rtl/rr_arb_mux_arbiter.sv
// Rotating-priority arbiter: holds the search pointer and grants the first
// requester at or after it (or from channel 0 in fixed-priority mode).
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_CH = 4,
  localparam int unsigned SELW = clog2_min1(N_CH)
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            mode_i,
  input  logic [N_CH-1:0] req_i,
  input  logic            en_i,
  output logic [N_CH-1:0] gnt_o,
  output logic [SELW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  logic [SELW-1:0] ptr_q, ptr_d;

  always_comb begin
    int unsigned base;
    int unsigned idx;
    logic [SELW-1:0] idx_s;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    base        = (mode_i == MODE_FIXED) ? 0 : 32'(ptr_q);
    idx         = 0;
    idx_s       = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = base + k;
      if (idx >= N_CH) idx = idx - N_CH;
      idx_s = SELW'(idx);
      if (!gnt_valid_o && req_i[idx_s]) begin
        gnt_idx_o   = idx_s;
        gnt_valid_o = 1'b1;
      end
    end
    gnt_o = gnt_valid_o ? (N_CH'(1) << gnt_idx_o) : '0;
  end

  // Pointer only advances on an actual transfer in round-robin mode.
  always_comb begin
    ptr_d = ptr_q;
    if (en_i && gnt_valid_o && (mode_i == MODE_RR)) begin
      ptr_d = (32'(gnt_idx_o) == N_CH - 1) ? '0 : gnt_idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel arbitrated multiplexer with a single registered output stage and
// valid/ready handshakes on every input and on the output.
module rr_arb_mux
  import rr_arb_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 64,
  localparam int unsigned SELW = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mode,
  input  logic [N_CH-1:0]       in_valid,
  input  logic [N_CH*WIDTH-1:0] in_data,
  output logic [N_CH-1:0]       in_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [SELW-1:0]       out_sel,
  input  logic                  out_ready
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_sel_q, out_sel_d;

  logic             load;
  logic             xfer;
  logic [N_CH-1:0]  gnt;
  logic [SELW-1:0]  gnt_idx;
  logic             gnt_valid;
  logic [WIDTH-1:0] sel_data;

  // Nothing is accepted while reset is asserted.
  assign load = ~reset & (~out_valid_q | out_ready);
  assign xfer = load & gnt_valid;

  rr_arbiter #(
    .N_CH (N_CH)
  ) u_arbiter (
    .clk_i       (clk),
    .reset_i     (reset),
    .mode_i      (mode),
    .req_i       (in_valid),
    .en_i        (load),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (gnt[i]) sel_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sel_data;
      out_sel_d   = gnt_idx;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
    end
  end

  assign in_ready  = load ? gnt : '0;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed scenarios on a 4-channel instance and
// randomized traffic on 4-, 1- and 5-channel instances against a queue-based model.
module tb_rr_arb_mux;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic mode = 1'b0;

  logic [3:0]   iv4 = '0;
  logic [255:0] id4 = '0;
  logic [3:0]   ir4;
  logic         ov4;
  logic [63:0]  od4;
  logic [1:0]   os4;
  logic         ordy4 = 1'b0;

  logic [0:0]   iv1 = '0;
  logic [63:0]  id1 = '0;
  logic [0:0]   ir1;
  logic         ov1;
  logic [63:0]  od1;
  logic [0:0]   os1;
  logic         ordy1 = 1'b0;

  logic [4:0]   iv5 = '0;
  logic [319:0] id5 = '0;
  logic [4:0]   ir5;
  logic         ov5;
  logic [63:0]  od5;
  logic [2:0]   os5;
  logic         ordy5 = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.N_CH(4), .WIDTH(64)) dut4 (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(iv4), .in_data(id4), .in_ready(ir4),
    .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(ordy4)
  );

  rr_arb_mux #(.N_CH(1), .WIDTH(64)) dut1 (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(iv1), .in_data(id1), .in_ready(ir1),
    .out_valid(ov1), .out_data(od1), .out_sel(os1), .out_ready(ordy1)
  );

  rr_arb_mux #(.N_CH(5), .WIDTH(64)) dut5 (
    .clk(clk), .reset(reset), .mode(mode), .in_valid(iv5), .in_data(id5), .in_ready(ir5),
    .out_valid(ov5), .out_data(od5), .out_sel(os5), .out_ready(ordy5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    reset = 1'b1;
    mode  = 1'b0;
    iv4 = '0; iv1 = '0; iv5 = '0;
    ordy4 = 1'b0; ordy1 = 1'b0; ordy5 = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic drive(input int which, input logic [7:0] v, input logic [63:0] d [8],
                       input logic r);
    case (which)
      4: begin
        iv4 = v[3:0];
        for (int c = 0; c < 4; c++) id4[c*64 +: 64] = d[c];
        ordy4 = r;
      end
      1: begin
        iv1 = v[0:0];
        id1 = d[0];
        ordy1 = r;
      end
      default: begin
        iv5 = v[4:0];
        for (int c = 0; c < 5; c++) id5[c*64 +: 64] = d[c];
        ordy5 = r;
      end
    endcase
  endtask

  task automatic sample(input int which, output logic [7:0] ir, output logic ov,
                        output logic [63:0] od, output logic [7:0] os);
    case (which)
      4: begin ir = {4'b0, ir4}; ov = ov4; od = od4; os = {6'b0, os4}; end
      1: begin ir = {7'b0, ir1}; ov = ov1; od = od1; os = {7'b0, os1}; end
      default: begin ir = {3'b0, ir5}; ov = ov5; od = od5; os = {5'b0, os5}; end
    endcase
  endtask

  task automatic test_reset();
    reset_all();
    mode = 1'b0;
    iv4 = 4'hF;
    for (int c = 0; c < 4; c++) id4[c*64 +: 64] = 64'h1111_0000_0000_0000 + 64'(c);
    ordy4 = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    tests++;
    if (ir4 !== 4'b0000) begin
      fails++; $display("FAIL reset_in_ready_during: got %b expected 0000", ir4);
    end
    tick();
    tests++;
    if (ov4 !== 1'b0 || od4 !== 64'h0 || os4 !== 2'd0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b d=%h s=%0d expected v=0 d=0 s=0", ov4, od4, os4);
    end
    reset = 1'b0;
    iv4 = 4'h0;
    #1;
    tests++;
    if (ir4 !== 4'b0000) begin
      fails++; $display("FAIL reset_in_ready_after: got %b expected 0000", ir4);
    end
    // The pointer had moved to 1 before reset; channel 0 winning proves it returned to 0.
    iv4 = 4'hF;
    ordy4 = 1'b1;
    tick();
    tests++;
    if (ov4 !== 1'b1 || os4 !== 2'd0) begin
      fails++; $display("FAIL reset_ptr: got v=%b s=%0d expected v=1 s=0", ov4, os4);
    end
  endtask

  task automatic test_round_robin();
    logic [63:0] d [4];
    reset_all();
    mode = 1'b0;
    for (int c = 0; c < 4; c++) begin
      d[c] = {$urandom, $urandom};
      id4[c*64 +: 64] = d[c];
    end
    iv4 = 4'hF;
    ordy4 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      tests++;
      if (ir4 !== 4'(1 << (k % 4))) begin
        fails++; $display("FAIL rr_in_ready[%0d]: got %b expected %b", k, ir4, 4'(1 << (k % 4)));
      end
      tick();
      tests++;
      if (ov4 !== 1'b1 || os4 !== 2'(k % 4) || od4 !== d[k % 4]) begin
        fails++;
        $display("FAIL rr_beat[%0d]: got v=%b s=%0d d=%h expected v=1 s=%0d d=%h",
                 k, ov4, os4, od4, k % 4, d[k % 4]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    logic [63:0] d [4];
    reset_all();
    mode = 1'b1;
    for (int c = 0; c < 4; c++) begin
      d[c] = {$urandom, $urandom};
      id4[c*64 +: 64] = d[c];
    end
    iv4 = 4'b1010;
    ordy4 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (ir4 !== 4'b0010) begin
        fails++; $display("FAIL fixed_in_ready[%0d]: got %b expected 0010", k, ir4);
      end
      tick();
      tests++;
      if (os4 !== 2'd1 || od4 !== d[1]) begin
        fails++; $display("FAIL fixed_ch1[%0d]: got s=%0d d=%h expected s=1 d=%h", k, os4, od4, d[1]);
      end
    end
    iv4 = 4'b1000;
    tick();
    tests++;
    if (ov4 !== 1'b1 || os4 !== 2'd3 || od4 !== d[3]) begin
      fails++; $display("FAIL fixed_ch3: got v=%b s=%0d d=%h expected v=1 s=3 d=%h", ov4, os4, od4, d[3]);
    end
  endtask

  task automatic test_stall();
    logic [63:0] d [4];
    reset_all();
    mode = 1'b0;
    for (int c = 0; c < 4; c++) begin
      d[c] = {$urandom, $urandom};
      id4[c*64 +: 64] = d[c];
    end
    iv4 = 4'hF;
    ordy4 = 1'b1;
    tick();
    ordy4 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (ir4 !== 4'b0000) begin
        fails++; $display("FAIL stall_in_ready[%0d]: got %b expected 0000", k, ir4);
      end
      tick();
      tests++;
      if (ov4 !== 1'b1 || os4 !== 2'd0 || od4 !== d[0]) begin
        fails++; $display("FAIL stall_hold[%0d]: got v=%b s=%0d d=%h expected v=1 s=0 d=%h",
                          k, ov4, os4, od4, d[0]);
      end
    end
    ordy4 = 1'b1;
    #1;
    tests++;
    if (ir4 !== 4'b0010) begin
      fails++; $display("FAIL stall_release_ready: got %b expected 0010", ir4);
    end
    tick();
    tests++;
    if (ov4 !== 1'b1 || os4 !== 2'd1 || od4 !== d[1]) begin
      fails++; $display("FAIL stall_release_beat: got v=%b s=%0d d=%h expected v=1 s=1 d=%h",
                        ov4, os4, od4, d[1]);
    end
  endtask

  task automatic test_wrap();
    int exp_seq [3] = '{3, 0, 3};
    reset_all();
    mode = 1'b0;
    ordy4 = 1'b1;
    iv4 = 4'b0100;
    tick();
    iv4 = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (os4 !== 2'(exp_seq[k])) begin
        fails++; $display("FAIL wrap[%0d]: got s=%0d expected s=%0d", k, os4, exp_seq[k]);
      end
    end
  endtask

  task automatic test_random(input int which, input int n, input int cycles);
    logic [7:0]  hv;
    logic [63:0] hd [8];
    logic [7:0]  ir, exp_ir, os;
    logic        ov, od_v, ordy, m_ov, m_mode;
    logic [63:0] od;
    logic [63:0] exp_d [$];
    int          exp_s [$];
    int          waits [8];
    int          m_ptr, g, base, idx;
    logic [63:0] ed;
    int          es;
    reset_all();
    hv = '0;
    for (int c = 0; c < 8; c++) begin hd[c] = '0; waits[c] = 0; end
    m_ptr = 0;
    m_ov  = 1'b0;
    for (int cyc = 0; cyc <= cycles; cyc++) begin
      m_mode = (cyc < cycles / 2) ? 1'b0 : 1'($urandom_range(0, 1));
      if (cyc == cycles) begin
        hv = '0;
        ordy = 1'b1;
      end else begin
        for (int c = 0; c < n; c++) begin
          if (!hv[c] && ($urandom_range(0, 9) < 6)) begin
            hv[c] = 1'b1;
            hd[c] = {$urandom, $urandom};
          end
        end
        ordy = ($urandom_range(0, 9) < 7);
      end
      mode = m_mode;
      drive(which, hv, hd, ordy);
      #1;
      sample(which, ir, ov, od, os);
      g = -1;
      base = m_mode ? 0 : m_ptr;
      for (int k = 0; k < n; k++) begin
        idx = (base + k) % n;
        if (g < 0 && hv[idx]) g = idx;
      end
      exp_ir = ((!m_ov || ordy) && g >= 0) ? 8'(1 << g) : 8'h00;
      tests++;
      if (ir !== exp_ir) begin
        fails++; $display("FAIL rand%0d_in_ready[%0d]: got %b expected %b", which, cyc, ir, exp_ir);
      end
      tests++;
      if (ov !== m_ov) begin
        fails++; $display("FAIL rand%0d_out_valid[%0d]: got %b expected %b", which, cyc, ov, m_ov);
      end
      od_v = m_ov && ordy;
      if (od_v) begin
        tests++;
        if (exp_d.size() == 0) begin
          fails++; $display("FAIL rand%0d_dup[%0d]: got beat s=%0d expected none", which, cyc, os);
        end else begin
          ed = exp_d.pop_front();
          es = exp_s.pop_front();
          if (od !== ed || os !== 8'(es)) begin
            fails++; $display("FAIL rand%0d_beat[%0d]: got s=%0d d=%h expected s=%0d d=%h",
                              which, cyc, os, od, es, ed);
          end
        end
      end
      if ((!m_ov || ordy) && g >= 0) begin
        exp_d.push_back(hd[g]);
        exp_s.push_back(g);
        if (!m_mode) begin
          tests++;
          if (waits[g] > n - 1) begin
            fails++; $display("FAIL rand%0d_starve[%0d]: got wait=%0d expected <=%0d",
                              which, cyc, waits[g], n - 1);
          end
          for (int c = 0; c < n; c++) if (hv[c] && c != g) waits[c]++;
          m_ptr = (g + 1) % n;
        end
        waits[g] = 0;
        hv[g] = 1'b0;
        m_ov = 1'b1;
      end else if (ordy) begin
        m_ov = 1'b0;
      end
      if (m_mode) for (int c = 0; c < 8; c++) waits[c] = 0;
      tick();
    end
    sample(which, ir, ov, od, os);
    tests++;
    if (ov !== 1'b0 || exp_d.size() != 0) begin
      fails++; $display("FAIL rand%0d_drain: got v=%b pending=%0d expected v=0 pending=0",
                        which, ov, exp_d.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fixed_priority();
    test_stall();
    test_wrap();
    test_random(4, 4, 2000);
    test_random(1, 1, 800);
    test_random(5, 5, 1500);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
